// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared constants, types and helpers for the 4-digit BCD calculator ALU.
//   - opcode encodings (OP_ADD .. OP_POW; 101-111 are reserved)
//   - datapath widths (BCD digits, packed-BCD width, binary width)
//   - ERR_CODE (never a valid BCD pattern) and MAX_VAL (largest displayable)
//   - stage-1 pipeline register layout
//   - sat_mul: 14x14 multiply clamped at SAT_VAL, used by the power unit
// -----------------------------------------------------------------------------
package bcd_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int BCD_W      = 4 * NUM_DIGITS;
  // 9999 needs 14 bits; this binary width only covers the 4-digit build.
  localparam int BIN_W      = 14;
  localparam int PROD_W     = 2 * BIN_W;

  localparam logic [BCD_W-1:0] ERR_CODE      = 16'hFFFF;
  localparam logic [BIN_W-1:0] MAX_VAL       = 14'd9999;
  // Clamp value for power intermediates: anything >= 10000 is already an
  // overflow, so 10000 is enough to remember "too big" without wider maths.
  localparam logic [BIN_W-1:0] SAT_VAL       = 14'd10000;
  // For bases >= 2, an exponent of 14 or more always overflows (2^14 > 9999).
  localparam logic [BIN_W-1:0] POW_EXP_LIMIT = 14'd14;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_POW = 3'b100;

  // Stage-1 register: operands already in binary, plus flags.
  //   vld - a real sample occupies the stage (cleared by reset)
  //   bad - at least one operand nibble was > 9
  typedef struct packed {
    logic             vld;
    logic             bad;
    logic [2:0]       op;
    logic [BIN_W-1:0] a;
    logic [BIN_W-1:0] b;
  } stage1_t;

  function automatic logic [BIN_W-1:0] sat_mul(input logic [BIN_W-1:0] x,
                                               input logic [BIN_W-1:0] y);
    logic [PROD_W-1:0] p;
    p = {{BIN_W{1'b0}}, x} * {{BIN_W{1'b0}}, y};
    return (p >= PROD_W'(SAT_VAL)) ? SAT_VAL : p[BIN_W-1:0];
  endfunction

endpackage

// File: rtl/bcd_alu_if.sv
// -----------------------------------------------------------------------------
// bcd_alu_if
// Operand/result bundle between key-entry logic (master) and the ALU (slave).
//   num1 - operand A, packed BCD, digit 3 in [15:12]
//   num2 - operand B, packed BCD
//   op   - opcode (see bcd_pkg)
//   res  - registered result, packed BCD or ERR_CODE
// -----------------------------------------------------------------------------
interface bcd_alu_if;
  import bcd_pkg::*;

  logic [BCD_W-1:0] num1;
  logic [BCD_W-1:0] num2;
  logic [2:0]       op;
  logic [BCD_W-1:0] res;

  modport master (output num1, output num2, output op, input res);
  modport slave  (input num1, input num2, input op, output res);

endinterface

// File: rtl/bin2bcd.sv
// -----------------------------------------------------------------------------
// bin2bcd
// Combinational 14-bit binary to 4-digit packed-BCD converter (double-dabble).
//   bin_i - binary value; callers only present values 0..9999
//   bcd_o - packed BCD, digit 3 in [15:12]
// -----------------------------------------------------------------------------
module bin2bcd
  import bcd_pkg::*;
(
  input  logic [BIN_W-1:0] bin_i,
  output logic [BCD_W-1:0] bcd_o
);

  // BCD digits sit above the binary bits; the binary part is shifted into
  // them one bit per step.
  logic [BCD_W+BIN_W-1:0] shift_d;

  always_comb begin
    shift_d = {{BCD_W{1'b0}}, bin_i};
    for (int i = 0; i < BIN_W; i++) begin
      // Any digit >= 5 would become >= 10 after doubling; pre-adding 3
      // makes the shift carry into the next digit instead.
      for (int d = 0; d < NUM_DIGITS; d++) begin
        if (shift_d[BIN_W + 4*d +: 4] >= 4'd5) begin
          shift_d[BIN_W + 4*d +: 4] = shift_d[BIN_W + 4*d +: 4] + 4'd3;
        end
      end
      shift_d = shift_d << 1;
    end
    bcd_o = shift_d[BIN_W +: BCD_W];
  end

endmodule

// File: rtl/bcd_alu.sv
// -----------------------------------------------------------------------------
// bcd_alu
// Two-stage registered BCD arithmetic unit for the calculator datapath.
//   clk - system clock, all state on the rising edge
//   rst - synchronous active-high reset; clears both stages and res
//   bus - bcd_alu_if.slave: num1/num2/op in, res out
// Inputs stable before edge N appear on res after edge N+1. A new sample is
// accepted every cycle with no handshake.
// Stage 1: packed BCD -> binary per operand, flag any nibble > 9.
// Stage 2: add/sub/mul/div/pow in binary, range check, binary -> BCD.
// Every error (invalid digit, reserved op, divide by zero, overflow,
// negative) produces ERR_CODE.
// -----------------------------------------------------------------------------
module bcd_alu #(
  parameter int                  DIGITS   = bcd_pkg::NUM_DIGITS,
  parameter logic [4*DIGITS-1:0] ERR_CODE = bcd_pkg::ERR_CODE
) (
  input  logic      clk,
  input  logic      rst,
  bcd_alu_if.slave  bus
);
  import bcd_pkg::*;

  localparam int W = 4 * DIGITS;

  // ---------------------------------------------------------------------------
  // Stage 1: BCD -> binary
  // ---------------------------------------------------------------------------
  logic [DIGITS-1:0] bad1;
  logic [DIGITS-1:0] bad2;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit_chk
    assign bad1[gi] = (bus.num1[4*gi +: 4] > 4'd9);
    assign bad2[gi] = (bus.num2[4*gi +: 4] > 4'd9);
  end

  // Horner form: ((d3*10 + d2)*10 + d1)*10 + d0.
  function automatic logic [BIN_W-1:0] bcd_to_bin(input logic [W-1:0] v);
    logic [BIN_W-1:0] acc;
    acc = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      acc = acc * 14'd10 + {{(BIN_W-4){1'b0}}, v[4*i +: 4]};
    end
    return acc;
  endfunction

  stage1_t s1_d;
  stage1_t s1_q;

  always_comb begin
    s1_d     = '0;
    s1_d.vld = 1'b1;
    s1_d.bad = (|bad1) | (|bad2);
    s1_d.op  = bus.op;
    s1_d.a   = bcd_to_bin(bus.num1);
    s1_d.b   = bcd_to_bin(bus.num2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
    end else begin
      s1_q <= s1_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: arithmetic units
  // ---------------------------------------------------------------------------
  logic [BIN_W:0]    sum;
  logic [PROD_W-1:0] prod;

  assign sum  = {1'b0, s1_q.a} + {1'b0, s1_q.b};
  assign prod = {{BIN_W{1'b0}}, s1_q.a} * {{BIN_W{1'b0}}, s1_q.b};

  // Restoring divider, one quotient bit per dividend bit, MSB first.
  // The partial remainder is always < divisor, so it fits in BIN_W bits.
  logic [BIN_W-1:0] quo;
  logic [BIN_W-1:0] rem;
  logic [BIN_W:0]   part;

  always_comb begin
    quo  = '0;
    rem  = '0;
    part = '0;
    for (int i = BIN_W - 1; i >= 0; i--) begin
      part = {rem, s1_q.a[i]};
      if (part >= {1'b0, s1_q.b}) begin
        part   = part - {1'b0, s1_q.b};
        quo[i] = 1'b1;
      end
      rem = part[BIN_W-1:0];
    end
  end

  // Square-and-multiply over the low four exponent bits. Only exponents
  // below 14 reach the result, so four bits are enough; intermediates clamp
  // at SAT_VAL so an overflow stays visible without a wide accumulator.
  logic [BIN_W-1:0] pow_acc;
  logic [BIN_W-1:0] pow_base;

  always_comb begin
    pow_acc  = 14'd1;
    pow_base = s1_q.a;
    for (int i = 0; i < 4; i++) begin
      if (s1_q.b[i]) begin
        pow_acc = sat_mul(pow_acc, pow_base);
      end
      pow_base = sat_mul(pow_base, pow_base);
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: result select and range check
  // ---------------------------------------------------------------------------
  logic [BIN_W-1:0] val;
  logic             rsvd_op;
  logic             div_zero;
  logic             range_err;
  logic             any_err;

  always_comb begin
    val       = '0;
    rsvd_op   = 1'b0;
    div_zero  = 1'b0;
    range_err = 1'b0;
    case (s1_q.op)
      OP_ADD: begin
        if (sum > {1'b0, MAX_VAL}) range_err = 1'b1;
        else                       val = sum[BIN_W-1:0];
      end
      OP_SUB: begin
        if (s1_q.a < s1_q.b) range_err = 1'b1;
        else                 val = s1_q.a - s1_q.b;
      end
      OP_MUL: begin
        if (prod > PROD_W'(MAX_VAL)) range_err = 1'b1;
        else                         val = prod[BIN_W-1:0];
      end
      OP_DIV: begin
        if (s1_q.b == '0) div_zero = 1'b1;
        else              val = quo;
      end
      OP_POW: begin
        // Exponent 0 wins over base 0, so 0^0 = 1. Bases 0 and 1 are fixed
        // points for any exponent, so the exponent limit does not apply.
        if (s1_q.b == '0)                  val = 14'd1;
        else if (s1_q.a == '0)             val = '0;
        else if (s1_q.a == 14'd1)          val = 14'd1;
        else if (s1_q.b >= POW_EXP_LIMIT)  range_err = 1'b1;
        else if (pow_acc > MAX_VAL)        range_err = 1'b1;
        else                               val = pow_acc;
      end
      default: rsvd_op = 1'b1;
    endcase
  end

  // All error kinds share one code, so precedence only matters for the
  // reason, not for the output pattern.
  assign any_err = s1_q.bad | rsvd_op | div_zero | range_err;

  logic [BCD_W-1:0] val_bcd;

  bin2bcd u_bin2bcd (
    .bin_i (val),
    .bcd_o (val_bcd)
  );

  logic [W-1:0] res_d;
  logic [W-1:0] res_q;

  // An empty stage 1 (right after reset) yields 0000, not an error.
  always_comb begin
    res_d = '0;
    if (s1_q.vld) begin
      res_d = any_err ? ERR_CODE : W'(val_bcd);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q <= '0;
    end else begin
      res_q <= res_d;
    end
  end

  assign bus.res = res_q;

endmodule

// File: tb/tb_bcd_alu.sv
module tb_bcd_alu;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   in_reset = 1'b1;

  bcd_alu_if bus ();

  bcd_alu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] exp;
    int          due;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  op;
    bit          is_rst;
  } exp_t;

  exp_t sb[$];

  function automatic bit bcd_ok(input logic [15:0] v);
    for (int i = 0; i < 4; i++) if (v[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int bcd2int(input logic [15:0] v);
    int r = 0;
    for (int i = 3; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [15:0] int2bcd(input int n);
    logic [15:0] r;
    int t = n;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [15:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic [2:0] op);
    int x, y;
    longint r;
    if (!bcd_ok(a) || !bcd_ok(b)) return 16'hFFFF;
    x = bcd2int(a);
    y = bcd2int(b);
    case (op)
      3'd0: r = x + y;
      3'd1: r = x - y;
      3'd2: r = longint'(x) * y;
      3'd3: begin
        if (y == 0) return 16'hFFFF;
        r = x / y;
      end
      3'd4: begin
        r = 1;
        for (int i = 0; i < y; i++) begin
          r = r * x;
          if (r > 9999 || r == 0) break;
        end
      end
      default: return 16'hFFFF;
    endcase
    if (r < 0 || r > 9999) return 16'hFFFF;
    return int2bcd(int'(r));
  endfunction

  task automatic push(input logic [15:0] e, input int due, input logic [15:0] a,
                      input logic [15:0] b, input logic [2:0] op, input bit is_rst);
    exp_t t;
    t.exp = e; t.due = due; t.a = a; t.b = b; t.op = op; t.is_rst = is_rst;
    sb.push_back(t);
  endtask

  task automatic do_reset(input int n);
    sb.delete();
    rst = 1'b1;
    in_reset = 1'b1;
    repeat (n) begin
      push(16'h0000, cyc + 1, bus.num1, bus.num2, bus.op, 1'b1);
      @(posedge clk); #1;
    end
  endtask

  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
    rst = 1'b0;
    bus.num1 = a;
    bus.num2 = b;
    bus.op   = op;
    if (in_reset) begin
      push(16'h0000, cyc + 1, a, b, op, 1'b1);
      in_reset = 1'b0;
    end
    push(model(a, b, op), cyc + 2, a, b, op, 1'b0);
    @(posedge clk); #1;
  endtask

  function automatic logic [15:0] rnd_operand();
    int m = int'($urandom_range(0, 15));
    logic [15:0] v;
    int idx;
    if (m == 0) begin
      v = 16'($urandom);
      idx = int'($urandom_range(0, 3));
      v[4*idx +: 4] = 4'($urandom_range(10, 15));
    end else if (m < 6) begin
      v = int2bcd(int'($urandom_range(0, 12)));
    end else if (m < 9) begin
      v = int2bcd(int'($urandom_range(0, 120)));
    end else begin
      v = int2bcd(int'($urandom_range(0, 9999)));
    end
    return v;
  endfunction

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].due < cyc) begin
        e = sb.pop_front();
        n_cmp++;
        n_bad++;
        $display("FAIL missed_res: due cycle %0d not checked (now %0d), required %h",
                 e.due, cyc, e.exp);
      end
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        n_cmp++;
        if (bus.res !== e.exp) begin
          n_bad++;
          $display("FAIL %s cyc=%0d num1=%h num2=%h op=%0d: res=%h required=%h",
                   e.is_rst ? "reset_res" : "alu_res", cyc, e.a, e.b, e.op,
                   bus.res, e.exp);
        end else begin
          $display("txn cyc=%0d %s num1=%h num2=%h op=%0d res=%h ok",
                   cyc, e.is_rst ? "reset" : "alu", e.a, e.b, e.op, bus.res);
        end
      end
    end
  end

  initial begin
    logic [2:0] rop;
    bus.num1 = 16'h0000;
    bus.num2 = 16'h0000;
    bus.op   = 3'b000;

    do_reset(3);
    drive(16'h0003, 16'h0004, 3'b000);

    drive(16'h0014, 16'h0007, 3'b011);
    drive(16'h0016, 16'h0007, 3'b011);
    drive(16'h0008, 16'h0000, 3'b011);
    drive(16'h0010, 16'h0010, 3'b010);
    drive(16'h0002, 16'h1000, 3'b010);
    drive(16'h9999, 16'h0002, 3'b010);
    drive(16'h9999, 16'h9999, 3'b001);
    drive(16'h9999, 16'h8999, 3'b001);
    drive(16'h0001, 16'h0002, 3'b001);
    drive(16'h5000, 16'h4000, 3'b000);
    drive(16'h5000, 16'h5000, 3'b000);
    drive(16'h4999, 16'h5000, 3'b000);
    drive(16'h0004, 16'h0002, 3'b100);
    drive(16'h0008, 16'h0000, 3'b100);
    drive(16'h0000, 16'h0000, 3'b100);
    drive(16'h0000, 16'h0005, 3'b100);
    drive(16'h0001, 16'h9999, 3'b100);
    drive(16'h0002, 16'h0013, 3'b100);
    drive(16'h0002, 16'h0014, 3'b100);
    drive(16'h0010, 16'h0004, 3'b100);
    drive(16'h0010, 16'h0003, 3'b100);
    drive(16'h00A0, 16'h0001, 3'b000);
    drive(16'h0001, 16'h000F, 3'b011);
    drive(16'h0003, 16'h0002, 3'b101);
    drive(16'h0003, 16'h0002, 3'b111);

    drive(16'h1234, 16'h0001, 3'b000);
    drive(16'h0500, 16'h0002, 3'b010);
    do_reset(1);
    drive(16'h0003, 16'h0004, 3'b000);

    for (int i = 0; i < 300; i++) begin
      rop = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7))
                                        : 3'($urandom_range(0, 4));
      drive(rnd_operand(), rnd_operand(), rop);
    end

    repeat (4) begin
      @(posedge clk); #1;
    end
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL drain_res: due cycle %0d never reached, required %h", e.due, e.exp);
    end

    rst = 1'b0;
    bus.num1 = 16'h0014;
    bus.num2 = 16'h0007;
    bus.op   = 3'b011;
    repeat (2) begin
      @(posedge clk); #1;
    end
    n_cmp++;
    if (bus.res !== 16'h0002) begin
      n_bad++;
      $display("FAIL direct_div: res=%h required=0002", bus.res);
    end else begin
      $display("txn direct div num1=0014 num2=0007 res=%h ok", bus.res);
    end

    bus.num1 = 16'h9999;
    bus.num2 = 16'h0002;
    bus.op   = 3'b010;
    repeat (2) begin
      @(posedge clk); #1;
    end
    n_cmp++;
    if (bus.res !== 16'hFFFF) begin
      n_bad++;
      $display("FAIL direct_mul_ovf: res=%h required=ffff", bus.res);
    end else begin
      $display("txn direct mul num1=9999 num2=0002 res=%h ok", bus.res);
    end

    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (bus.res !== 16'h0000) begin
      n_bad++;
      $display("FAIL direct_reset: res=%h required=0000", bus.res);
    end else begin
      $display("txn direct reset res=%h ok", bus.res);
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bcd_alu.md
Name: bcd_alu

Overview:
- Registered arithmetic unit for the 4-digit calculator datapath.
- Takes two unsigned 4-digit packed-BCD operands (0000–9999) and a 3-bit opcode.
- Produces a 4-digit packed-BCD result for add, subtract, multiply, integer divide and power.
- Sits between the operand/key-entry logic and the display driver. The display shows res directly.

Parameters:
- DIGITS, 4, number of BCD digits per operand/result; datapath width is 4*DIGITS.
- ERR_CODE, 16'hFFFF, result pattern for any error condition (never valid BCD).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- num1  input  16  operand A, packed BCD, digit 3 in [15:12]
- num2  input  16  operand B, packed BCD
- op  input  3  000 add, 001 sub, 010 mul, 011 div, 100 pow, 101–111 reserved
- res  output  16  result, packed BCD or ERR_CODE

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named rst. On a rst-high clock edge, all pipeline registers and res clear to 16'h0000.
- Latency: fixed 2-stage pipeline, no handshake; new inputs are accepted every cycle.
  - Edge 1 registers the binary-converted operands, op and an input-valid flag.
  - Edge 2 registers res.
  - Inputs stable before edge N produce res after edge N+1.
- Stage 1: BCD→binary per operand (d3*1000+d2*100+d1*10+d0, 14 bits). Any nibble > 9 sets the invalid flag.
- Stage 2: compute in binary (at least 27 bits for mul), range-check, then binary→BCD (double-dabble, combinational).
- add: A+B. A result > 9999 is an error.
- sub: A−B. A negative result is an error; A==B gives 0000.
- mul: A*B. A result > 9999 is an error.
- div: floor(A/B), remainder discarded. B==0 is an error. Combinational restoring divider, 14-bit.
- pow: A^B.
  - A^0 = 1 for all A, including 0^0 = 1.
  - 0^n = 0 and 1^n = 1 for n ≥ 1.
  - For A ≥ 2: B ≥ 14 is an error. Otherwise compute by unrolled square-and-multiply over B[3:0], saturating intermediates at 10000; a result > 9999 is an error.
- Any error, invalid BCD input, or reserved opcode gives res = ERR_CODE.
- Error precedence: invalid input > reserved op > divide-by-zero > overflow/negative (all give the same code).
- Changing op or operands mid-pipeline: each cycle's sample is independent; no interlock.
- Reset mid-operation discards in-flight samples. The first valid res is 2 edges after rst deasserts with stable inputs.

Decomposition:
- Shared package bcd_pkg:
  - opcode constants OP_ADD/OP_SUB/OP_MUL/OP_DIV/OP_POW
  - ERR_CODE and MAX_VAL = 9999
  - BCD width constants
- One natural sub-module: bin2bcd (14-bit binary → 4-digit packed BCD, double-dabble), instantiated in stage 2.
- BCD→binary conversion stays inline in bcd_alu.

Test Plan (after each input change, wait ≥ 2 clocks, then check res):
- div: num1=0x0014, num2=0x0007 → 0x0002. num1=0x0016, num2=0x0007 → 0x0002. num1=0x0008, num2=0x0000 → 0xFFFF.
- mul: 0x0010*0x0010 → 0x0100. 0x0002*0x1000 → 0x2000. 0x9999*0x0002 → 0xFFFF.
- sub: 0x9999−0x9999 → 0x0000. 0x9999−0x8999 → 0x1000. 0x0001−0x0002 → 0xFFFF.
- add/pow: 0x5000+0x4000 → 0x9000. 0x5000+0x5000 → 0xFFFF. pow 0x0004,0x0002 → 0x0016. pow 0x0008,0x0000 → 0x0001. pow 0x0002,0x0014 → 0xFFFF.
- invalid/reserved: num1=0x00A0 with any op → 0xFFFF. op=101 → 0xFFFF.
- reset/latency: with rst held, res=0x0000. Release rst with inputs 0x0003+0x0004: res=0x0000 after edge 1, 0x0007 after edge 2. Assert rst mid-stream: res=0x0000 on the next edge.
